// File: rtl/rx_word_align_if.sv
`default_nettype none
// ============================================================================
// Module   : rx_word_align_if
// Purpose  : Output bundle of the word aligner (aligned word, strobe, status)
// Revision : 1.0 - initial release
// ============================================================================
interface rx_word_align_if #(
  parameter int WORD_W = 10
);
  logic [WORD_W-1:0] dout;
  logic              valid;
  logic              is_comma;
  logic              locked;
  logic              align_err;

  // Aligner drives the bundle
  modport master (
    output dout,
    output valid,
    output is_comma,
    output locked,
    output align_err
  );

  // Frame/packet decoder consumes the bundle
  modport slave (
    input dout,
    input valid,
    input is_comma,
    input locked,
    input align_err
  );
endinterface
`default_nettype wire

// File: rtl/rx_word_align.sv
`default_nettype none
// ============================================================================
// Module   : rx_word_align
// Purpose  : Oversampled serial receiver. Recovers bit timing from data edges,
//            hunts for a comma (either disparity), qualifies word lock and
//            delivers LSB-first aligned words with lock / error status.
// Revision : 1.0 - initial release
// ============================================================================
module rx_word_align #(
  parameter int                OSR        = 4,
  parameter int                SAMPLE_PH  = 1,
  parameter int                WORD_W     = 10,
  parameter logic [WORD_W-1:0] COMMA      = 10'b0011111010,
  parameter int                LOCK_CNT   = 3,
  parameter int                ERR_MAX    = 4,
  parameter int                DROP_COMMA = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               LVDS,
  rx_word_align_if.master    o_bus
);

  localparam int PH_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam int BI_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int CC_W = $clog2(LOCK_CNT + 1);
  localparam int EC_W = $clog2(ERR_MAX + 1);

  localparam logic [PH_W-1:0]   c_PH_LAST   = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0]   c_PH_SAMPLE = PH_W'(SAMPLE_PH);
  localparam logic [BI_W-1:0]   c_BI_LAST   = BI_W'(WORD_W - 1);
  localparam logic [CC_W-1:0]   c_CC_LOCK   = CC_W'(LOCK_CNT);
  localparam logic [EC_W-1:0]   c_EC_MAX    = EC_W'(ERR_MAX);
  localparam logic [WORD_W-1:0] c_COMMA_N   = ~COMMA;

  typedef enum logic [1:0] {
    S_HUNT   = 2'd0,
    S_SYNC   = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  // Synchroniser and edge history
  logic              r_sync1;
  logic              r_sync2;
  logic              r_hist;
  logic              w_edge;

  // Bit timing recovery
  logic [PH_W-1:0]   r_phase;
  logic              w_bs;
  logic              r_bs_d;

  // Deserialiser
  logic [WORD_W-1:0] r_sr;
  logic              w_comma_match;

  // Word framing
  state_t            r_state;
  logic [BI_W-1:0]   r_bi;
  logic [BI_W-1:0]   w_bi_next;
  logic              w_boundary;
  logic [CC_W-1:0]   r_comma_cnt;
  logic [CC_W-1:0]   w_cc_inc;
  logic [EC_W-1:0]   r_err_cnt;
  logic [EC_W-1:0]   w_ec_inc;

  // Registered outputs
  logic [WORD_W-1:0] r_dout;
  logic              r_valid;
  logic              r_is_comma;
  logic              r_locked;
  logic              r_align_err;

  // Bring the asynchronous line into the clk domain and keep one history bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= LVDS;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 ^ r_hist;
  assign w_bs   = (r_phase == c_PH_SAMPLE);

  // Phase counter: realigned to every data edge, free-runs at OSR otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (w_edge || (r_phase == c_PH_LAST)) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

  // Shift sampled bits in at the MSB so the first bit ends up in bit 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr   <= '0;
      r_bs_d <= 1'b0;
    end else begin
      r_bs_d <= w_bs;
      if (w_bs) begin
        r_sr <= {r_sync2, r_sr[WORD_W-1:1]};
      end
    end
  end

  // Framing decisions are taken the cycle after a strobe, once r_sr holds
  // the newly received bit
  assign w_comma_match = (r_sr == COMMA) || (r_sr == c_COMMA_N);
  assign w_bi_next     = (r_bi == c_BI_LAST) ? '0 : (r_bi + 1'b1);
  assign w_boundary    = (w_bi_next == c_BI_LAST);
  assign w_cc_inc      = (r_comma_cnt == c_CC_LOCK) ? r_comma_cnt : (r_comma_cnt + 1'b1);
  assign w_ec_inc      = (r_err_cnt == c_EC_MAX) ? r_err_cnt : (r_err_cnt + 1'b1);

  // Lock state machine with its counters and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_HUNT;
      r_bi        <= '0;
      r_comma_cnt <= '0;
      r_err_cnt   <= '0;
      r_dout      <= '0;
      r_valid     <= 1'b0;
      r_is_comma  <= 1'b0;
      r_locked    <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_align_err <= 1'b0;
      if (r_bs_d) begin
        case (r_state)
          S_HUNT: begin
            r_locked <= 1'b0;
            if (w_comma_match) begin
              // The bit just received closes a word
              r_bi        <= c_BI_LAST;
              r_comma_cnt <= CC_W'(1);
              r_err_cnt   <= '0;
              r_state     <= (LOCK_CNT == 1) ? S_LOCKED : S_SYNC;
            end else begin
              r_bi <= w_bi_next;
            end
          end

          S_SYNC: begin
            if (w_comma_match) begin
              if (w_boundary) begin
                r_bi        <= w_bi_next;
                r_comma_cnt <= w_cc_inc;
                if (w_cc_inc == c_CC_LOCK) begin
                  r_err_cnt <= '0;
                  r_state   <= S_LOCKED;
                end
              end else begin
                // Comma seen at a new position: restart qualification there
                r_bi        <= c_BI_LAST;
                r_comma_cnt <= CC_W'(1);
              end
            end else begin
              r_bi <= w_bi_next;
              if (w_boundary) begin
                r_comma_cnt <= '0;
              end
            end
          end

          S_LOCKED: begin
            r_bi <= w_bi_next;
            if (w_boundary) begin
              // locked rises together with the first word emitted after lock
              r_dout     <= r_sr;
              r_is_comma <= w_comma_match;
              r_valid    <= !((DROP_COMMA != 0) && w_comma_match);
              r_locked   <= 1'b1;
              if (w_comma_match) begin
                r_err_cnt <= '0;
              end
            end else if (w_comma_match) begin
              // Misaligned comma: report it but keep the current alignment
              r_align_err <= 1'b1;
              r_err_cnt   <= w_ec_inc;
              if (w_ec_inc == c_EC_MAX) begin
                r_state     <= S_HUNT;
                r_locked    <= 1'b0;
                r_comma_cnt <= '0;
              end
            end
          end

          default: begin
            r_state  <= S_HUNT;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_bus.dout      = r_dout;
  assign o_bus.valid     = r_valid;
  assign o_bus.is_comma  = r_is_comma;
  assign o_bus.locked    = r_locked;
  assign o_bus.align_err = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_rx_word_align.sv
`default_nettype none
// ============================================================================
// Module   : tb_rx_word_align
// Purpose  : Directed bench for rx_word_align: a default 10-bit / OSR=4
//            instance and an 8-bit / OSR=8 / drop-comma / single-comma-lock
//            instance. Words are sent LSB first; captured valid words are
//            compared against a per-scenario table of expected outputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rx_word_align;

  localparam logic [9:0] C10 = 10'h0FA;  // comma, shift-register orientation
  localparam logic [9:0] N10 = 10'h305;  // inverted comma
  localparam logic [9:0] C8  = 10'h0BC;  // 8-bit comma, zero-extended
  localparam logic [9:0] W_A = 10'h3D5;  // carries comma bits 0..6 at offset 3
  localparam logic [9:0] W_B = 10'h2A9;  // carries comma bits 7..9 at offset 0

  logic clk = 1'b0;
  logic rst_n;
  logic lvds0;
  logic lvds8;

  always #5 clk = ~clk;

  rx_word_align_if #(.WORD_W(10)) if0 ();
  rx_word_align_if #(.WORD_W(8))  if8 ();

  rx_word_align #(
    .OSR(4), .SAMPLE_PH(1), .WORD_W(10), .COMMA(10'b0011111010),
    .LOCK_CNT(3), .ERR_MAX(4), .DROP_COMMA(0)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .LVDS(lvds0), .o_bus(if0.master)
  );

  rx_word_align #(
    .OSR(8), .SAMPLE_PH(3), .WORD_W(8), .COMMA(8'hBC),
    .LOCK_CNT(1), .ERR_MAX(4), .DROP_COMMA(1)
  ) u_dut8 (
    .clk(clk), .rst_n(rst_n), .LVDS(lvds8), .o_bus(if8.master)
  );

  typedef struct {
    int         scn;
    logic [9:0] word;
    bit         exp_v;
    bit         exp_c;
  } vec_t;

  typedef struct packed {
    logic [9:0] d;
    logic       c;
    logic       l;
  } cap_t;

  vec_t tv[$];
  cap_t q0[$];
  cap_t q8[$];
  logic ae0[$];
  int   ae8_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  bit jit_on   = 1'b0;
  bit jit_long = 1'b1;
  int bitcnt   = 0;

  function automatic void add_vec(int scn, logic [9:0] w, bit v, bit c);
    vec_t e;
    e.scn   = scn;
    e.word  = w;
    e.exp_v = v;
    e.exp_c = c;
    tv.push_back(e);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Capture every valid word and every align_err pulse
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (if0.valid === 1'b1) q0.push_back({if0.dout, if0.is_comma, if0.locked});
      if (if0.align_err === 1'b1) ae0.push_back(if0.locked);
      if (if8.valid === 1'b1) q8.push_back({2'b00, if8.dout, if8.is_comma, if8.locked});
      if (if8.align_err === 1'b1) ae8_cnt++;
    end
  end

  // One bit, optionally stretched or shortened by one clk every fifth bit
  task automatic send_bit(input int sel, input logic b, input int osr);
    int per;
    per = osr;
    if (jit_on) begin
      bitcnt++;
      if (bitcnt % 5 == 0) begin
        per      = jit_long ? osr + 1 : osr - 1;
        jit_long = !jit_long;
      end
    end
    if (sel == 0) lvds0 = b;
    else          lvds8 = b;
    repeat (per) @(negedge clk);
  endtask

  task automatic send_word(input int sel, input logic [9:0] w);
    int wid;
    int osr;
    wid = (sel == 0) ? 10 : 8;
    osr = (sel == 0) ? 4 : 8;
    for (int i = 0; i < wid; i++) send_bit(sel, w[i], osr);
  endtask

  task automatic do_reset();
    lvds0 = 1'b0;
    lvds8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    q0.delete();
    q8.delete();
    ae0.delete();
    ae8_cnt = 0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  // Send the words of one scenario, then compare the captured valid words
  task automatic run_scn(input int scn, input int sel);
    int osr;
    int n_left;
    cap_t c;
    osr = (sel == 0) ? 4 : 8;
    for (int i = 0; i < tv.size(); i++)
      if (tv[i].scn == scn) send_word(sel, tv[i].word);
    repeat (6 * osr) @(negedge clk);
    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].scn == scn && tv[i].exp_v) begin
        n_left = (sel == 0) ? q0.size() : q8.size();
        if (n_left == 0) begin
          check($sformatf("s%0d valid present [%0d]", scn, i), 32'd0, 32'd1);
        end else begin
          if (sel == 0) c = q0.pop_front();
          else          c = q8.pop_front();
          check($sformatf("s%0d dout [%0d]", scn, i), 32'(c.d), 32'(tv[i].word));
          check($sformatf("s%0d is_comma [%0d]", scn, i), 32'(c.c), 32'(tv[i].exp_c));
          check($sformatf("s%0d locked at valid [%0d]", scn, i), 32'(c.l), 32'd1);
        end
      end
    end
    n_left = (sel == 0) ? q0.size() : q8.size();
    check($sformatf("s%0d extra valid count", scn), 32'(n_left), 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " dout"},      32'(if0.dout),      32'd0);
    check({tag, " valid"},     32'(if0.valid),     32'd0);
    check({tag, " is_comma"},  32'(if0.is_comma),  32'd0);
    check({tag, " locked"},    32'(if0.locked),    32'd0);
    check({tag, " align_err"}, 32'(if0.align_err), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b1;
    lvds0   = 1'b0;
    lvds8   = 1'b0;
    ae8_cnt = 0;

    // Scenario 1: lock after reset, data word, inverted comma, data
    add_vec(1, C10, 0, 0); add_vec(1, C10, 0, 0); add_vec(1, C10, 0, 0);
    add_vec(1, 10'h2A5, 1, 0); add_vec(1, N10, 1, 1); add_vec(1, 10'h155, 1, 0);
    // Scenario 2: alternating disparity commas, then 4 data words
    add_vec(2, C10, 0, 0); add_vec(2, N10, 0, 0); add_vec(2, C10, 0, 0);
    for (int i = 0; i < 4; i++) add_vec(2, 10'h155, 1, 0);
    // Scenario 3: same framing under bit-period jitter
    add_vec(3, C10, 0, 0); add_vec(3, C10, 0, 0); add_vec(3, C10, 0, 0);
    add_vec(3, 10'h2A5, 1, 0); add_vec(3, 10'h3C3, 1, 0);
    add_vec(3, 10'h0F0, 1, 0); add_vec(3, 10'h155, 1, 0);
    // Scenario 4: four commas shifted by 3 bits while locked, then re-lock
    add_vec(4, C10, 0, 0); add_vec(4, C10, 0, 0); add_vec(4, C10, 0, 0);
    for (int r = 0; r < 4; r++) begin
      add_vec(4, 10'h155, 1, 0);
      add_vec(4, W_A, 1, 0);
      add_vec(4, W_B, (r < 3), 0);
    end
    add_vec(4, C10, 0, 0); add_vec(4, C10, 0, 0); add_vec(4, C10, 0, 0);
    add_vec(4, 10'h155, 1, 0);
    // Scenario 5: comma run interrupted by a data word
    add_vec(5, C10, 0, 0); add_vec(5, C10, 0, 0); add_vec(5, 10'h155, 0, 0);
    add_vec(5, C10, 0, 0); add_vec(5, C10, 0, 0); add_vec(5, C10, 0, 0);
    add_vec(5, 10'h2A5, 1, 0);
    // Scenario 6: 8-bit instance, single-comma lock, commas dropped
    add_vec(6, C8, 0, 0); add_vec(6, 10'h000, 1, 0); add_vec(6, 10'h0FF, 1, 0);
    add_vec(6, C8, 0, 0); add_vec(6, 10'h0FF, 1, 0); add_vec(6, 10'h000, 1, 0);

    // Asynchronous reset before any clock edge
    #2 rst_n = 1'b0;
    #1 check_outputs_zero("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_scn(2, 0);
    check("s2 locked after stream", 32'(if0.locked), 32'd1);

    // Reset in the middle of a word while locked
    fork
      send_word(0, 10'h155);
      begin
        repeat (17) @(posedge clk);
        #3;
        check("pre-reset locked", 32'(if0.locked), 32'd1);
        rst_n = 1'b0;
        #1 check_outputs_zero("mid-stream reset");
      end
    join
    repeat (3) @(negedge clk);
    q0.delete();
    ae0.delete();
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    run_scn(1, 0);
    check("s1 align_err count", 32'(ae0.size()), 32'd0);

    do_reset();
    jit_on   = 1'b1;
    jit_long = 1'b1;
    bitcnt   = 0;
    run_scn(3, 0);
    jit_on   = 1'b0;
    check("s3 align_err count", 32'(ae0.size()), 32'd0);

    do_reset();
    run_scn(4, 0);
    check("s4 align_err count", 32'(ae0.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < ae0.size())
        check($sformatf("s4 locked at align_err %0d", k), 32'(ae0[k]), (k < 3) ? 32'd1 : 32'd0);
    end
    check("s4 re-locked", 32'(if0.locked), 32'd1);

    do_reset();
    run_scn(5, 0);

    do_reset();
    run_scn(6, 8);
    check("s6 align_err count", 32'(ae8_cnt), 32'd0);
    check("s6 locked", 32'(if8.locked), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rx_word_align.md
Name: rx_word_align

Overview:
- Parametrised successor to the fixed 4x/10-bit LVDS stop-word receiver.
- Oversamples a single-ended serial line (post-LVDS buffer) at OSR× the bit rate and recovers bit timing from data edges.
- Detects a comma in either disparity, qualifies word lock with a state machine, and emits aligned WORD_W-bit words with lock and error status.
- Sits between the LVDS input pin and the frame/packet decoder.

Parameters:
- OSR, 4: oversampling ratio, clk cycles per bit; legal values 3..16.
- SAMPLE_PH, 1: phase-counter value at which a bit is sampled; must be < OSR.
- WORD_W, 10: word width in bits.
- COMMA, 10'b0011111010: comma pattern, compared in shift-register orientation. ~COMMA is also accepted.
- LOCK_CNT, 3: consecutive aligned commas needed to declare lock; legal 1..15.
- ERR_MAX, 4: misaligned commas in LOCKED that force re-hunt; legal 1..15.
- DROP_COMMA, 0: 1 = comma words do not assert valid.

Ports:
- clk input 1: sample clock, OSR × bit rate.
- rst_n input 1: asynchronous active-low reset.
- LVDS input 1: serial bit stream, asynchronous to clk.
- dout output WORD_W: last aligned word; bit 0 = first bit received.
- valid output 1: one-cycle strobe, dout updated.
- is_comma output 1: qualifies dout; 1 when dout equals COMMA or ~COMMA.
- locked output 1: high in LOCKED state.
- align_err output 1: one-cycle pulse per misaligned comma while LOCKED.

Behaviour:
- Reset:
  - dout=0, valid=0, is_comma=0, locked=0, align_err=0.
  - State=HUNT; all counters and the shift register cleared; synchroniser flops cleared.
  - Reset is asynchronous and may assert at any time; the block restarts from HUNT with no residual lock.
- Input synchroniser:
  - 2-flop synchroniser followed by 1 history flop.
  - edge = sync_q ^ hist_q.
- Phase counter, 0..OSR-1:
  - Forced to 0 on the cycle after edge; otherwise increments and wraps at OSR-1.
  - Bit strobe bs asserts when phase==SAMPLE_PH. It is a single cycle per bit and never repeats within one bit period.
  - No edge for many bits: free-runs at OSR period.
- Shift register:
  - WORD_W bits. On bs, the new bit enters the MSB and the register shifts right (LSB-first word order).
  - comma_hit = (sr==COMMA || sr==~COMMA), evaluated on the cycle after bs.
- Bit index bi, 0..WORD_W-1:
  - Increments on each bs and wraps.
  - Boundary = the bs that takes bi to WORD_W-1.
- State machine:
  - HUNT:
    - On comma_hit: bi set so the current bit is a boundary, comma_cnt=1.
    - If LOCK_CNT==1, go to LOCKED; otherwise go to SYNC.
  - SYNC:
    - Aligned comma_hit (at a boundary): comma_cnt++. Reaching LOCK_CNT goes to LOCKED.
    - Misaligned comma_hit: realign bi to the current bit, comma_cnt=1, stay in SYNC.
    - Aligned non-comma word: comma_cnt=0, stay in SYNC.
    - No output in SYNC.
  - LOCKED:
    - At every boundary: dout<=sr and is_comma<=comma_hit. valid=1 for one cycle unless DROP_COMMA and comma_hit.
    - Aligned comma: err_cnt=0.
    - Misaligned comma: align_err pulses and err_cnt++. Alignment is not changed.
    - err_cnt reaching ERR_MAX: go to HUNT. locked drops the same cycle, and no valid is issued for that word.
- Latency: valid rises 2 clk after the bs of the word's last bit (1 cycle for comma_hit, 1 cycle for the output register).
- locked rises on the same cycle as the first valid-eligible boundary after the LOCK_CNT-th aligned comma. The locking comma itself is not output.
- Simultaneous events:
  - Edge on the same cycle as phase==SAMPLE_PH: the sample is still taken and the phase is reset afterwards.
  - Aligned comma and err_cnt threshold cannot coincide, because an aligned comma clears err_cnt.
- Counter widths: sized with $clog2 of their maxima; comma_cnt and err_cnt saturate and do not wrap.

Test Plan:
- Reset with default parameters:
  - Assert rst_n mid-stream -> all outputs 0 within the same cycle, state HUNT.
  - After release: 3 aligned commas (0011111010) -> locked=1.
  - Then word 0x2A5 -> dout=0x2A5, valid=1, is_comma=0.
- Alternating disparity: stream COMMA, ~COMMA, COMMA, then data 0x155 ×4 -> locked after the 3rd comma; 4 valid pulses with dout=0x155.
- Phase tolerance: bit period jitter ±1 clk every 5 bits (OSR=4) -> all words recovered bit-exact, no align_err.
- Misalignment while LOCKED:
  - Inject a comma shifted by 3 bits, 4 times, with data in between -> 4 align_err pulses.
  - locked=0 after the 4th; re-lock after 3 aligned commas.
- SYNC interruption: 2 aligned commas, 1 data word, 3 commas -> lock only after the final 3; no valid before locked.
- Parameter sweep: OSR=8, WORD_W=8, COMMA=8'hBC, DROP_COMMA=1, LOCK_CNT=1 -> locked after the first comma; no valid on comma words; data bytes 0x00/0xFF delivered correctly.
